// File: rtl/change_dispenser_if.sv
// Bus between a sales controller and the change dispenser.
// Master drives the load/tender/cancel controls; slave returns coin and status.
interface change_dispenser_if #(
  parameter int unsigned W = 5
);

  logic         L;
  logic [W-1:0] Due;
  logic         P;
  logic [W-1:0] X;
  logic         C;
  logic         Ready;
  logic [1:0]   Coin;
  logic         CoinValid;
  logic         Paid;
  logic         Refunded;

  modport master (
    output L, Due, P, X, C,
    input  Ready, Coin, CoinValid, Paid, Refunded
  );

  modport slave (
    input  L, Due, P, X, C,
    output Ready, Coin, CoinValid, Paid, Refunded
  );

endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: loads an amount due, accumulates tenders (saturating),
// then pays out change (or a full refund on cancel) one coin per cycle,
// greedy largest-coin first, and pulses Paid or Refunded when finished.
// Build option: define CHANGE_DISPENSER_COIN10_EN to enable the 10-unit coin;
// otherwise only 5- and 1-unit coins are dispensed.
module change_dispenser #(
  parameter int unsigned W = 5
) (
  input logic              Clock,
  input logic              Reset,
  change_dispenser_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAITPAY = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_DISP    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [W-1:0] AMT_1  = W'(1);
  localparam logic [W-1:0] AMT_5  = W'(5);
  localparam logic [W-1:0] AMT_10 = W'(10);

  localparam logic [1:0] COIN_1  = 2'd0;
  localparam logic [1:0] COIN_5  = 2'd1;
  localparam logic [1:0] COIN_10 = 2'd2;

`ifdef CHANGE_DISPENSER_COIN10_EN
  localparam bit COIN10_EN = 1'b1;
`else
  localparam bit COIN10_EN = 1'b0;
`endif

  logic [2:0]   state, state_d;
  logic [W-1:0] dreg, dreg_d;
  logic [W-1:0] preg, preg_d;
  logic [W-1:0] creg, creg_d;
  logic         rf, rf_d;

  logic [W:0]   pay_sum;
  logic [W-1:0] pay_sat;

  logic         ready_c;
  logic [1:0]   coin_c;
  logic         coin_valid_c;
  logic         paid_c;
  logic         refunded_c;

  // Saturating accumulation of the tendered amount.
  assign pay_sum = {1'b0, preg} + {1'b0, bus.X};
  assign pay_sat = pay_sum[W] ? '1 : pay_sum[W-1:0];

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
      dreg  <= '0;
      preg  <= '0;
      creg  <= '0;
      rf    <= 1'b0;
    end else begin
      state <= state_d;
      dreg  <= dreg_d;
      preg  <= preg_d;
      creg  <= creg_d;
      rf    <= rf_d;
    end
  end

  // Next-state, datapath update and Moore-decoded outputs.
  always_comb begin
    state_d      = state;
    dreg_d       = dreg;
    preg_d       = preg;
    creg_d       = creg;
    rf_d         = rf;
    ready_c      = 1'b0;
    coin_c       = COIN_1;
    coin_valid_c = 1'b0;
    paid_c       = 1'b0;
    refunded_c   = 1'b0;

    case (state)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.L) begin
          dreg_d  = bus.Due;
          preg_d  = '0;
          rf_d    = 1'b0;
          state_d = S_WAITPAY;
        end
      end

      S_WAITPAY: begin
        if (bus.C) begin
          creg_d  = preg;
          rf_d    = 1'b1;
          state_d = S_DISP;
        end else if (bus.P) begin
          preg_d  = pay_sat;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (preg >= dreg) begin
          creg_d  = preg - dreg;
          state_d = S_DISP;
        end else begin
          state_d = S_WAITPAY;
        end
      end

      S_DISP: begin
        if (creg != '0) begin
          coin_valid_c = 1'b1;
          if (COIN10_EN && (creg >= AMT_10)) begin
            coin_c = COIN_10;
            creg_d = creg - AMT_10;
          end else if (creg >= AMT_5) begin
            coin_c = COIN_5;
            creg_d = creg - AMT_5;
          end else begin
            coin_c = COIN_1;
            creg_d = creg - AMT_1;
          end
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        paid_c     = ~rf;
        refunded_c = rf;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status and coin outputs are decoded from the current state.
  assign bus.Ready     = ready_c;
  assign bus.Coin      = coin_c;
  assign bus.CoinValid = coin_valid_c;
  assign bus.Paid      = paid_c;
  assign bus.Refunded  = refunded_c;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed vector table, reset corner cases and
// randomized transactions checked against an arithmetic reference model.
module tb_change_dispenser;

  localparam int unsigned W = 5;
  localparam int AMT_MAX = (1 << W) - 1;

`ifdef CHANGE_DISPENSER_COIN10_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic Clock;
  logic Reset;

  change_dispenser_if #(.W(W)) bus ();

  change_dispenser #(.W(W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string name;
    int    due;
    int    xs[3];
    int    nx;
    int    cancel_at;
    bit    c_chk;
    bit    exp_paid;
    int    n_en;
    int    coins_en[8];
    int    n_nen;
    int    coins_nen[8];
  } vec_t;

  vec_t vecs[8];

  int n_pass  = 0;
  int n_total = 0;

  int seen[$];
  int exp_q[$];
  int paid_n, ref_n, bad_n, first_coin, p_cyc;
  int cyc_n = 0;
  bit timed_out, rdy_load, tail_ok;

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // One clock; afterwards outputs reflect the new state and are recorded.
  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
    cyc_n++;
    if (bus.CoinValid) begin
      seen.push_back(int'(bus.Coin));
      if (first_coin < 0) first_coin = cyc_n;
    end else if (bus.Coin != 2'd0) begin
      bad_n++;
    end
    if (bus.Ready && (bus.CoinValid || bus.Paid || bus.Refunded)) bad_n++;
    if (bus.Paid) paid_n++;
    if (bus.Refunded) ref_n++;
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > AMT_MAX) ? AMT_MAX : a + b;
  endfunction

  // Greedy coin list for an amount, computed with division.
  task automatic build_exp(input int amt);
    int tens, rem, fives, ones;
    exp_q.delete();
    tens  = EN ? amt / 10 : 0;
    rem   = amt - 10 * tens;
    fives = rem / 5;
    ones  = rem % 5;
    repeat (tens)  exp_q.push_back(2);
    repeat (fives) exp_q.push_back(1);
    repeat (ones)  exp_q.push_back(0);
  endtask

  // Transaction outcome: sale completes once the saturated sum covers due,
  // otherwise everything paid is refunded.
  task automatic model(input int due, input int xs[3], input int nx, input int cancel_at,
                       output bit paid, output int amt);
    int  sum;
    bit  stop;
    sum  = 0;
    paid = 1'b0;
    stop = 1'b0;
    amt  = 0;
    for (int i = 0; i < nx; i++) begin
      if (!stop) begin
        sum = sat_add(sum, xs[i]);
        if (sum >= due) begin
          paid = 1'b1;
          stop = 1'b1;
        end else if (i == cancel_at) begin
          stop = 1'b1;
        end
      end
    end
    amt = paid ? sum - due : sum;
  endtask

  task automatic run_txn(input int due, input int xs[3], input int nx, input int cancel_at,
                         input bit c_chk, input bit noise);
    int n, sum;
    bit done;
    bus.L = 1'b0; bus.P = 1'b0; bus.C = 1'b0;
    n = 0;
    while (!bus.Ready && n < 50) begin
      tick();
      n++;
    end
    seen.delete();
    paid_n = 0; ref_n = 0; bad_n = 0; first_coin = -1; p_cyc = -1;
    timed_out = (n >= 50);

    bus.L = 1'b1; bus.Due = W'(due);
    tick();
    bus.L = 1'b0;
    rdy_load = bus.Ready;

    sum  = 0;
    done = 1'b0;
    for (int i = 0; i < nx; i++) begin
      if (!done) begin
        bus.P = 1'b1; bus.X = W'(xs[i]);
        if (noise) begin bus.L = 1'b1; bus.Due = W'($urandom); end
        p_cyc = cyc_n;
        tick();
        bus.P = 1'b0; bus.L = 1'b0;
        sum = sat_add(sum, xs[i]);
        bus.C = c_chk;
        if (noise) begin bus.P = 1'b1; bus.X = W'($urandom); end
        tick();
        bus.C = 1'b0; bus.P = 1'b0;
        if (sum >= due) done = 1'b1;
        else if (i == cancel_at) begin
          bus.C = 1'b1;
          if (noise) begin bus.P = 1'b1; bus.X = W'($urandom); end
          tick();
          bus.C = 1'b0; bus.P = 1'b0;
          done = 1'b1;
        end
      end
    end
    if (!done) begin
      bus.C = 1'b1;
      tick();
      bus.C = 1'b0;
    end

    n = 0;
    while (paid_n == 0 && ref_n == 0 && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) timed_out = 1'b1;
    tick();
    tail_ok = bus.Ready && !bus.Paid && !bus.Refunded;
  endtask

  task automatic compare_txn(input string nm, input bit exp_paid);
    check({nm, ".timeout"}, int'(timed_out), 0);
    check({nm, ".ready_busy"}, int'(rdy_load), 0);
    check({nm, ".ncoins"}, seen.size(), exp_q.size());
    for (int i = 0; i < seen.size() && i < exp_q.size(); i++)
      check($sformatf("%s.coin%0d", nm, i), seen[i], exp_q[i]);
    check({nm, ".paid"}, paid_n, exp_paid ? 1 : 0);
    check({nm, ".refunded"}, ref_n, exp_paid ? 0 : 1);
    check({nm, ".idle_outputs"}, bad_n, 0);
    check({nm, ".back_to_ready"}, int'(tail_ok), 1);
    if (exp_paid && exp_q.size() > 0)
      check({nm, ".latency"}, first_coin - p_cyc, 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit  m_paid;
    int  m_amt;
    int  xs[3];
    int  nx, cancel_at;
    vec_t v;

    vecs[0] = '{"due13_x20", 13, '{20, 0, 0}, 1, -1, 1'b0, 1'b1,
                3, '{1, 0, 0, 0, 0, 0, 0, 0}, 3, '{1, 0, 0, 0, 0, 0, 0, 0}};
    vecs[1] = '{"due6_split", 6, '{3, 3, 0}, 2, -1, 1'b0, 1'b1,
                0, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, '{0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[2] = '{"due4_x31", 4, '{31, 0, 0}, 1, -1, 1'b0, 1'b1,
                5, '{2, 2, 1, 0, 0, 0, 0, 0}, 7, '{1, 1, 1, 1, 1, 0, 0, 0}};
    vecs[3] = '{"cancel_9", 20, '{9, 0, 0}, 1, 0, 1'b0, 1'b0,
                5, '{1, 0, 0, 0, 0, 0, 0, 0}, 5, '{1, 0, 0, 0, 0, 0, 0, 0}};
    vecs[4] = '{"sat_c_in_check", 30, '{20, 20, 0}, 2, -1, 1'b1, 1'b1,
                1, '{0, 0, 0, 0, 0, 0, 0, 0}, 1, '{0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[5] = '{"due0_x0", 0, '{0, 0, 0}, 1, -1, 1'b0, 1'b1,
                0, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, '{0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[6] = '{"due0_x31", 0, '{31, 0, 0}, 1, -1, 1'b0, 1'b1,
                4, '{2, 2, 2, 0, 0, 0, 0, 0}, 7, '{1, 1, 1, 1, 1, 1, 0, 0}};
    vecs[7] = '{"cancel_empty", 5, '{0, 0, 0}, 0, -1, 1'b0, 1'b0,
                0, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, '{0, 0, 0, 0, 0, 0, 0, 0}};

    // Reset, with L asserted to confirm reset dominates.
    Reset = 1'b1;
    bus.L = 1'b0; bus.Due = '0; bus.P = 1'b0; bus.X = '0; bus.C = 1'b0;
    tick();
    bus.L = 1'b1; bus.Due = W'(9);
    tick();
    bus.L = 1'b0;
    check("reset.ready", int'(bus.Ready), 1);
    check("reset.coin", int'(bus.Coin), 0);
    check("reset.coin_valid", int'(bus.CoinValid), 0);
    check("reset.paid", int'(bus.Paid), 0);
    check("reset.refunded", int'(bus.Refunded), 0);
    Reset = 1'b0;
    tick();

    // Directed vector table.
    for (int k = 0; k < 8; k++) begin
      v = vecs[k];
      run_txn(v.due, v.xs, v.nx, v.cancel_at, v.c_chk, 1'b0);
      exp_q.delete();
      if (EN) for (int i = 0; i < v.n_en; i++) exp_q.push_back(v.coins_en[i]);
      else    for (int i = 0; i < v.n_nen; i++) exp_q.push_back(v.coins_nen[i]);
      compare_txn(v.name, v.exp_paid);
    end

    // Reset in the second Dispense cycle, then a clean sale.
    bus.L = 1'b1; bus.Due = W'(13);
    tick();
    bus.L = 1'b0; bus.P = 1'b1; bus.X = W'(20);
    tick();
    bus.P = 1'b0;
    tick();
    tick();
    check("mid_rst.pre_valid", int'(bus.CoinValid), 1);
    check("mid_rst.pre_coin", int'(bus.Coin), 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst.coin_valid", int'(bus.CoinValid), 0);
    check("mid_rst.ready", int'(bus.Ready), 1);
    xs = '{5, 0, 0};
    run_txn(5, xs, 1, -1, 1'b0, 1'b0);
    build_exp(0);
    compare_txn("after_rst", 1'b1);

    // Randomized transactions against the reference model.
    for (int t = 0; t < 60; t++) begin
      nx = int'($urandom_range(1, 3));
      for (int i = 0; i < 3; i++) xs[i] = int'($urandom_range(0, 20));
      cancel_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nx - 1)) : -1;
      v.due = int'($urandom_range(0, AMT_MAX));
      run_txn(v.due, xs, nx, cancel_at, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      model(v.due, xs, nx, cancel_at, m_paid, m_amt);
      build_exp(m_amt);
      compare_txn($sformatf("rand%0d", t), m_paid);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter W, default 5: bit width of all amounts (unsigned).
REQ-002 SHALL have port Clock  input  1  rising-edge clock.
REQ-003 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port L  input  1  load amount due from Due (honoured in Idle only).
REQ-005 SHALL have port Due  input  W  amount owed (unsigned), typically the register Total.
REQ-006 SHALL have port P  input  1  tender strobe: add X to amount paid.
REQ-007 SHALL have port X  input  W  tendered amount (unsigned).
REQ-008 SHALL have port C  input  1  cancel: refund everything paid so far.
REQ-009 SHALL have port Ready  output  1  high in Idle.
REQ-010 SHALL have port Coin  output  2  coin code: 0=1 unit, 1=5 units, 2=10 units.
REQ-011 SHALL have port CoinValid  output  1  Coin is dispensed this cycle.
REQ-012 SHALL have port Paid  output  1  one-cycle pulse: sale completed.
REQ-013 SHALL have port Refunded  output  1  one-cycle pulse: sale cancelled.

Function
REQ-014 SHALL hold W-bit registers DREG (due), PREG (paid), CREG (change remaining), and a 1-bit flag RF (refund).
REQ-015 SHALL implement the states Idle, WaitPay, Check, Dispense and Done.
REQ-016 Idle: on L, SHALL set DREG<=Due, PREG<=0 and RF<=0, then go to WaitPay; otherwise it SHALL stay in Idle.
REQ-017 SHALL ignore L, P and C when they are not honoured by the current state.
REQ-018 WaitPay: C SHALL take priority: CREG<=PREG, RF<=1, go to Dispense.
REQ-019 WaitPay: otherwise, on P, SHALL set PREG<=PREG+X, saturating at 2^W-1, then go to Check.
REQ-020 WaitPay: with neither C nor P, SHALL stay in WaitPay.
REQ-021 Check: if PREG>=DREG, SHALL set CREG<=PREG-DREG and go to Dispense; otherwise SHALL return to WaitPay. C SHALL be ignored in Check.
REQ-022 Dispense: CoinValid SHALL equal (CREG!=0), decoded combinationally from state and CREG.
REQ-023 Dispense, coin selection, greedy:
- CREG>=10 and 10-unit coin enabled: Coin=2, CREG-=10
- else CREG>=5: Coin=1, CREG-=5
- else CREG>=1: Coin=0, CREG-=1
REQ-024 Dispense: when CREG==0, CoinValid SHALL be 0 and the next state SHALL be Done; zero change therefore costs exactly one cycle in Dispense.
REQ-025 Done: Paid SHALL equal !RF and Refunded SHALL equal RF for that single cycle, then go to Idle.
REQ-026 Latency from a P that completes payment to the first CoinValid SHALL be 2 cycles (WaitPay edge, then Check edge).
REQ-027 Due=0 SHALL still require one P; X=0 is then a valid completing tender.
REQ-028 Coin SHALL be 0 whenever CoinValid=0.
REQ-029 Ready, CoinValid, Paid and Refunded SHALL be 0 outside the states stated above.

Reset
REQ-030 Reset=1 at a clock edge SHALL force Idle and clear DREG, PREG, CREG and RF, in any state including mid-Dispense.
REQ-031 Reset SHALL take priority over all other inputs.
REQ-032 In the cycle after reset: Ready=1, Coin=0, CoinValid=0, Paid=0, Refunded=0.
REQ-033 No coin already counted SHALL be repeated after reset.

Configuration
REQ-034 With macro CHANGE_DISPENSER_COIN10_EN defined, the 10-unit coin (Coin=2) SHALL be used per REQ-023.
REQ-035 Without CHANGE_DISPENSER_COIN10_EN, Coin SHALL never equal 2; only 5 and 1 SHALL be dispensed, with the same state sequence.

Verification (W=5)
REQ-036 L with Due=13, P with X=20 -> change 7: Coin 1,0,0 on three consecutive CoinValid cycles, then a Paid pulse, then Ready.
REQ-037 Due=6; P X=3 -> back to WaitPay; P X=3 -> Dispense with zero CoinValid cycles, then Paid pulse.
REQ-038 Due=4, P X=31 -> change 27: with EN, Coin 2,2,1,0,0; without EN, Coin 1,1,1,1,1,0,0.
REQ-039 Due=20; P X=9; C in WaitPay -> refund 9: Coin 1,0,0,0,0, then Refunded=1 and Paid=0.
REQ-040 Due=30; P X=20; P X=20 -> PREG saturates at 31 -> change 1: Coin 0, then Paid; C asserted during Check has no effect.
REQ-041 Reset asserted during the second Dispense cycle -> CoinValid=0 and Ready=1 the next cycle; a following L with Due=5 and P with X=5 completes normally.
